// File: rtl/jogo_pkg.sv
// Shared types, flash states and default colours for the ball renderer.
package jogo_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [23:0] cor_t;

  typedef enum logic {
    NORMAL   = 1'b0,
    PISCANDO = 1'b1
  } estado_pisca_t;

  localparam cor_t COR_BOLA_PADRAO  = 24'hFFFFFF;
  localparam cor_t COR_PISCA_PADRAO = 24'hFF0000;
  localparam cor_t COR_BORDA_PADRAO = 24'h00FF00;

  // |a-b| through an 11-bit signed difference; the magnitude always fits in 10 bits.
  function automatic coord_t dist_abs(input coord_t a, input coord_t b);
    logic signed [10:0] diff;
    logic [10:0]        mag;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = diff[10] ? 11'(-diff) : 11'(diff);
    return mag[9:0];
  endfunction

endpackage

// File: rtl/quadrado_dist.sv
// Two-stage |a-b|^2 slice: stage 1 registers the magnitude, stage 2 its square.
module quadrado_dist
  import jogo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  coord_t      a,
  input  coord_t      b,
  output logic [19:0] quad
);

  coord_t      dist_q, dist_d;
  logic [19:0] quad_q, quad_d;

  always_comb begin
    dist_d = dist_abs(a, b);
    quad_d = {10'd0, dist_q} * {10'd0, dist_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_q <= '0;
      quad_q <= '0;
    end else begin
      dist_q <= dist_d;
      quad_q <= quad_d;
    end
  end

  assign quad = quad_q;

endmodule

// File: rtl/renderizador_bola.sv
// Ball renderer: 3-cycle pixel pipeline against frame-latched shadows plus a hit-flash FSM.
// Optional outline colour enabled with macro BOLA_BORDA_EN.
module renderizador_bola
  import jogo_pkg::*;
#(
  parameter cor_t        COR_BOLA      = COR_BOLA_PADRAO,
  parameter cor_t        COR_PISCA     = COR_PISCA_PADRAO,
  parameter cor_t        COR_BORDA     = COR_BORDA_PADRAO,
  parameter int unsigned QUADROS_PISCA = 8
) (
  input  logic   CLOCK_50,
  input  logic   reset,
  input  coord_t pixel_x,
  input  coord_t pixel_y,
  input  logic   pixel_valido,
  input  logic   inicio_quadro,
  input  coord_t bola_x,
  input  coord_t bola_y,
  input  coord_t bola_raio,
  input  logic   atingiu,
  input  logic   pausa,
  output logic   pixel_bola,
  output logic   valido_saida,
  output cor_t   cor
);

  localparam logic [7:0] CARGA_PISCA = 8'(QUADROS_PISCA);

  // Shadow copy of the ball, refreshed only at the frame boundary.
  coord_t sx_q, sx_d;
  coord_t sy_q, sy_d;
  coord_t sr_q, sr_d;

  logic        v1_q, v1_d;
  logic        v2_q, v2_d;
  logic        v3_q, v3_d;
  logic [19:0] r2_1_q, r2_1_d;
  logic [19:0] r2_2_q, r2_2_d;
  logic [19:0] dx2, dy2;
  logic [20:0] d2;
  logic        dentro;
  logic        pixel_bola_q, pixel_bola_d;
  cor_t        cor_q, cor_d;
  cor_t        cor_preench;

  estado_pisca_t estado_q, estado_d;
  logic [7:0]    cnt_q, cnt_d;

`ifdef BOLA_BORDA_EN
  coord_t      raio_int;
  logic [19:0] ri2_1_q, ri2_1_d;
  logic [19:0] ri2_2_q, ri2_2_d;
`endif

  quadrado_dist u_dist_x (
    .clk  (CLOCK_50),
    .rst_n(reset),
    .a    (pixel_x),
    .b    (sx_q),
    .quad (dx2)
  );

  quadrado_dist u_dist_y (
    .clk  (CLOCK_50),
    .rst_n(reset),
    .a    (pixel_y),
    .b    (sy_q),
    .quad (dy2)
  );

  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    sr_d = sr_q;
    if (inicio_quadro) begin
      sx_d = bola_x;
      sy_d = bola_y;
      sr_d = bola_raio;
    end
  end

  always_comb begin
    v1_d   = pixel_valido;
    r2_1_d = {10'd0, sr_q} * {10'd0, sr_q};
    v2_d   = v1_q;
    r2_2_d = r2_1_q;
    v3_d   = v2_q;
`ifdef BOLA_BORDA_EN
    raio_int = (sr_q > 10'd2) ? (sr_q - 10'd2) : 10'd0;
    ri2_1_d  = {10'd0, raio_int} * {10'd0, raio_int};
    ri2_2_d  = ri2_1_q;
`endif
  end

  // Hit reload has priority over the per-frame decrement.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    if (atingiu) begin
      estado_d = PISCANDO;
      cnt_d    = CARGA_PISCA;
    end else if (estado_q == PISCANDO && inicio_quadro && !pausa) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) begin
        estado_d = NORMAL;
      end
    end
  end

  always_comb begin
    cor_preench = COR_BOLA;
    if (estado_q == PISCANDO && cnt_q[1]) begin
      cor_preench = COR_PISCA;
    end
    d2           = {1'b0, dx2} + {1'b0, dy2};
    dentro       = v2_q && (d2 < {1'b0, r2_2_q});
    pixel_bola_d = dentro;
    cor_d        = '0;
    if (dentro) begin
      cor_d = cor_preench;
`ifdef BOLA_BORDA_EN
      if (d2 >= {1'b0, ri2_2_q}) begin
        cor_d = COR_BORDA;
      end
`endif
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sx_q         <= '0;
      sy_q         <= '0;
      sr_q         <= '0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      r2_1_q       <= '0;
      r2_2_q       <= '0;
      pixel_bola_q <= 1'b0;
      cor_q        <= '0;
      estado_q     <= NORMAL;
      cnt_q        <= '0;
    end else begin
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      sr_q         <= sr_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      v3_q         <= v3_d;
      r2_1_q       <= r2_1_d;
      r2_2_q       <= r2_2_d;
      pixel_bola_q <= pixel_bola_d;
      cor_q        <= cor_d;
      estado_q     <= estado_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef BOLA_BORDA_EN
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ri2_1_q <= '0;
      ri2_2_q <= '0;
    end else begin
      ri2_1_q <= ri2_1_d;
      ri2_2_q <= ri2_2_d;
    end
  end
`endif

  assign pixel_bola   = pixel_bola_q;
  assign valido_saida = v3_q;
  assign cor          = cor_q;

endmodule

// File: tb/tb_renderizador_bola.sv
// Directed bench for renderizador_bola: geometry, latency, shadows, flash FSM, reset, radius edges.
module tb_renderizador_bola;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        pixel_valido = 1'b0;
  logic        inicio_quadro = 1'b0;
  logic [9:0]  bola_x = '0, bola_y = '0, bola_raio = '0;
  logic        atingiu = 1'b0;
  logic        pausa = 1'b0;
  logic        pixel_bola;
  logic        valido_saida;
  logic [23:0] cor;

  int tests = 0;
  int fails = 0;

  localparam logic [23:0] BRANCO   = 24'hFFFFFF;
  localparam logic [23:0] VERMELHO = 24'hFF0000;
`ifdef BOLA_BORDA_EN
  localparam logic [23:0] COR_ARO = 24'h00FF00;
  localparam logic [23:0] COR_R1  = 24'h00FF00;
`else
  localparam logic [23:0] COR_ARO = 24'hFFFFFF;
  localparam logic [23:0] COR_R1  = 24'hFFFFFF;
`endif

  // red=1 expected after the k-th frame pulse of an 8-frame flash (counts 7..0)
  logic [7:0] tabela_vermelho = 8'b0011_0011;

  renderizador_bola dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .pixel_valido (pixel_valido),
    .inicio_quadro(inicio_quadro),
    .bola_x       (bola_x),
    .bola_y       (bola_y),
    .bola_raio    (bola_raio),
    .atingiu      (atingiu),
    .pausa        (pausa),
    .pixel_bola   (pixel_bola),
    .valido_saida (valido_saida),
    .cor          (cor)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel, checked exactly 3 clock edges after it is sampled.
  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic exp_bola, input logic [23:0] exp_cor);
    @(negedge CLOCK_50);
    pixel_x = x; pixel_y = y; pixel_valido = 1'b1;
    @(negedge CLOCK_50);
    pixel_valido = 1'b0;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    chk({tag, ".bola"}, {31'd0, pixel_bola}, {31'd0, exp_bola});
    chk({tag, ".cor"}, {8'd0, cor}, {8'd0, exp_cor});
    chk({tag, ".valido"}, {31'd0, valido_saida}, 32'd1);
    $display("[TB] pixel %s (%0d,%0d) bola=%0b cor=%06h", tag, x, y, pixel_bola, cor);
  endtask

  task automatic quadro();
    @(negedge CLOCK_50);
    inicio_quadro = 1'b1;
    @(negedge CLOCK_50);
    inicio_quadro = 1'b0;
  endtask

  task automatic batida();
    @(negedge CLOCK_50);
    atingiu = 1'b1;
    @(negedge CLOCK_50);
    atingiu = 1'b0;
  endtask

  initial begin
    // reset state
    bola_x = 10'd300; bola_y = 10'd300; bola_raio = 10'd50;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst.bola", {31'd0, pixel_bola}, 32'd0);
    chk("rst.valido", {31'd0, valido_saida}, 32'd0);
    chk("rst.cor", {8'd0, cor}, 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;

    // shadows still zero before the first frame pulse
    pix("pre_quadro", 10'd300, 10'd300, 1'b0, 24'h0);

    quadro();

    // exact latency: nothing at edge 2, result at edge 3
    @(negedge CLOCK_50);
    pixel_x = 10'd300; pixel_y = 10'd300; pixel_valido = 1'b1;
    @(negedge CLOCK_50);
    pixel_valido = 1'b0;
    @(posedge CLOCK_50);
    #1;
    chk("lat2.bola", {31'd0, pixel_bola}, 32'd0);
    chk("lat2.valido", {31'd0, valido_saida}, 32'd0);
    @(posedge CLOCK_50);
    #1;
    chk("lat3.bola", {31'd0, pixel_bola}, 32'd1);
    chk("lat3.cor", {8'd0, cor}, {8'd0, BRANCO});
    chk("lat3.valido", {31'd0, valido_saida}, 32'd1);

    pix("p349_300", 10'd349, 10'd300, 1'b1, COR_ARO);
    pix("p350_300", 10'd350, 10'd300, 1'b0, 24'h0);
    pix("p335_335", 10'd335, 10'd335, 1'b1, COR_ARO);
    pix("p336_336", 10'd336, 10'd336, 1'b0, 24'h0);
    pix("p340_300", 10'd340, 10'd300, 1'b1, BRANCO);
    pix("p251_300", 10'd251, 10'd300, 1'b1, COR_ARO);
    pix("p250_300", 10'd250, 10'd300, 1'b0, 24'h0);

    // mid-frame move must not show until the next frame pulse
    bola_x = 10'd400;
    pix("meio.velho", 10'd300, 10'd300, 1'b1, BRANCO);
    pix("meio.novo", 10'd400, 10'd300, 1'b0, 24'h0);
    quadro();
    pix("novo.novo", 10'd400, 10'd300, 1'b1, BRANCO);
    pix("novo.velho", 10'd300, 10'd300, 1'b0, 24'h0);
    bola_x = 10'd300;
    quadro();

    // flash: 8 frames, red on counts 7,6,3,2
    batida();
    pix("pisca.k0", 10'd300, 10'd300, 1'b1, BRANCO);
    for (int k = 0; k < 8; k++) begin
      quadro();
      pix($sformatf("pisca.k%0d", k + 1), 10'd300, 10'd300, 1'b1,
          tabela_vermelho[k] ? VERMELHO : BRANCO);
    end
    quadro();
    pix("pisca.fim", 10'd300, 10'd300, 1'b1, BRANCO);

    // pause freezes the counter at 7 (red)
    batida();
    quadro();
    pix("pausa.ini", 10'd300, 10'd300, 1'b1, VERMELHO);
    pausa = 1'b1;
    repeat (10) quadro();
    pix("pausa.fim", 10'd300, 10'd300, 1'b1, VERMELHO);
    pausa = 1'b0;

    // coincident hit and frame: reload to 8 wins (white), next frame gives 7 (red)
    @(negedge CLOCK_50);
    atingiu = 1'b1; inicio_quadro = 1'b1;
    @(negedge CLOCK_50);
    atingiu = 1'b0; inicio_quadro = 1'b0;
    pix("coinc.recarga", 10'd300, 10'd300, 1'b1, BRANCO);
    quadro();
    pix("coinc.seguinte", 10'd300, 10'd300, 1'b1, VERMELHO);

    // reset with a pixel stream in flight
    @(negedge CLOCK_50);
    pixel_x = 10'd300; pixel_y = 10'd300; pixel_valido = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("fluxo.bola", {31'd0, pixel_bola}, 32'd1);
    #2;
    reset = 1'b0;
    pixel_valido = 1'b0;
    #1;
    chk("rst_meio.bola", {31'd0, pixel_bola}, 32'd0);
    chk("rst_meio.cor", {8'd0, cor}, 32'd0);
    chk("rst_meio.valido", {31'd0, valido_saida}, 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLOCK_50);
      #1;
      chk($sformatf("descartado.c%0d", c), {31'd0, valido_saida}, 32'd0);
    end
    pix("pos_rst", 10'd300, 10'd300, 1'b0, 24'h0);
    quadro();
    pix("pos_rst.quadro", 10'd300, 10'd300, 1'b1, BRANCO);

    // radius edges
    bola_raio = 10'd0;
    quadro();
    pix("raio0", 10'd300, 10'd300, 1'b0, 24'h0);
    bola_raio = 10'd1;
    quadro();
    pix("raio1.centro", 10'd300, 10'd300, 1'b1, COR_R1);
    pix("raio1.viz", 10'd301, 10'd300, 1'b0, 24'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
